mult_div_unit: RTL and testbench

Sequential signed multiply/divide unit for the multicycle datapath. The control unit pulses `start` with an operation code, and the block iterates for 32 cycles, then loads its `hi`/`lo` result registers. Those registers feed the data inputs of the 8:1 write-back/ALU-source selection mux downstream. The control FSM stalls on `busy` and advances on `done`.

---
 rtl/mult_div_unit_pkg.sv | 16 +
 rtl/mult_div_unit_booth_step.sv | 28 ++
 rtl/mult_div_unit.sv | 125 ++++++++++++
 tb/tb_mult_div_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared op encoding, FSM state type and default operand width for the
// sequential multiply/divide unit and the control unit that drives it.
package mult_div_unit_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } md_state_t;

endpackage

// File: rtl/mult_div_unit_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand into the
// upper half of a 2*WIDTH+1 accumulator, then a one-bit arithmetic right shift.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic signed [2*WIDTH:0] acc,
    input  logic signed [WIDTH-1:0] mcand,
    output logic signed [2*WIDTH:0] acc_nxt
);

    logic signed [WIDTH:0] upper_ext;
    logic signed [WIDTH:0] mcand_ext;
    logic signed [WIDTH:0] sum;

    // The add is one bit wider than the upper half so that a most-negative
    // multiplicand cannot overflow before the shift folds the carry back in.
    always_comb begin
        upper_ext = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        mcand_ext = {mcand[WIDTH-1], mcand};
        case (acc[1:0])
            2'b01:   sum = upper_ext + mcand_ext;
            2'b10:   sum = upper_ext - mcand_ext;
            default: sum = upper_ext;
        endcase
        acc_nxt = {sum, acc[WIDTH:1]};
    end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (Booth) / divide (restoring) unit: WIDTH iterations
// per operation, results land in hi/lo on the final iteration edge.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last;
    logic             b_zero;

    logic                    op_r;
    logic signed [WIDTH-1:0] mcand_r;
    logic signed [2*WIDTH:0] acc_r;
    logic signed [2*WIDTH:0] acc_nxt;
    logic [WIDTH-1:0]        rem_r, quo_r, dvs_r;
    logic                    neg_q_r, neg_r_r;
    logic [WIDTH:0]          rem_sh;
    logic [WIDTH-1:0]        rem_sub, rem_nxt, quo_nxt;
    logic                    q_bit;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x,
                                                    input logic neg);
        return neg ? -x : x;
    endfunction

    assign accept = (state == IDLE) && start;
    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign b_zero = (b == '0);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    booth_step #(.WIDTH(WIDTH)) u_booth (
        .acc     (acc_r),
        .mcand   (mcand_r),
        .acc_nxt (acc_nxt)
    );

    // Restoring division step on magnitudes; the shifted remainder is at most
    // WIDTH+1 bits and any successful subtraction result fits back in WIDTH.
    always_comb begin
        rem_sh  = {rem_r, quo_r[WIDTH-1]};
        rem_sub = rem_sh[WIDTH-1:0] - dvs_r;
        q_bit   = (rem_sh >= {1'b0, dvs_r});
        rem_nxt = q_bit ? rem_sub : rem_sh[WIDTH-1:0];
        quo_nxt = {quo_r[WIDTH-2:0], q_bit};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (op == OP_DIV && b_zero) ? DONE : RUN;
            RUN:  if (last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt      <= '0;
                div_zero <= (op == OP_DIV) && b_zero;
            end else if (state == RUN) begin
                cnt <= cnt + CNT_W'(1);
                if (last) begin
                    if (op_r == OP_MULT) begin
                        hi <= acc_nxt[2*WIDTH:WIDTH+1];
                        lo <= acc_nxt[WIDTH:1];
                    end else begin
                        hi <= apply_sign(rem_nxt, neg_r_r);
                        lo <= apply_sign(quo_nxt, neg_q_r);
                    end
                end
            end
        end
    end

    // Working registers are pure datapath: loaded on accept, stepped in RUN.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_r    <= op;
            mcand_r <= a;
            acc_r   <= {{WIDTH{1'b0}}, b, 1'b0};
            rem_r   <= '0;
            quo_r   <= magnitude(a);
            dvs_r   <= magnitude(b);
            neg_q_r <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r_r <= a[WIDTH-1];
        end else if (state == RUN) begin
            acc_r <= acc_nxt;
            rem_r <= rem_nxt;
            quo_r <= quo_nxt;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: multiply, divide, divide by
// zero, ignored start during RUN and asynchronous reset abort.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        op;
    logic [31:0] a, b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_cmp  = 0;
    int n_fail = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request so it is sampled at the next rising edge (T0); returns
    // 1 time unit after T0 with the operands scrambled.
    task automatic start_op(input logic o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h1234_5678;
    endtask

    // Counts edges after T0 until done is seen; -1 if it never arrives.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        start   = 1'b0;
        op      = 1'b0;
        a       = '0;
        b       = '0;
        #1 reset_n = 1'b0;
        #11;
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
        n_cmp++; if (hi !== 32'h0)      begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0)      begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mult();
        int cyc;
        start_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_t0: got %b want 1", busy); end
        wait_done(cyc);
        n_cmp++; if (cyc !== 32) begin n_fail++; $display("FAIL mult_latency: got %0d want 32", cyc); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_neg_lo: got %h want ffffffeb", lo); end
        @(posedge clk);
        #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_width: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_after: got %b want 0", busy); end
        n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_hold_lo: got %h want ffffffeb", lo); end

        start_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(cyc);
        n_cmp++; if (cyc !== 32) begin n_fail++; $display("FAIL mult_min_latency: got %0d want 32", cyc); end
        n_cmp++; if (hi !== 32'h4000_0000) begin n_fail++; $display("FAIL mult_min_hi: got %h want 40000000", hi); end
        n_cmp++; if (lo !== 32'h0000_0000) begin n_fail++; $display("FAIL mult_min_lo: got %h want 00000000", lo); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_div();
        int cyc;
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc);
        n_cmp++; if (cyc !== 32) begin n_fail++; $display("FAIL div_latency: got %0d want 32", cyc); end
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_quo: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_rem: got %h want ffffffff", hi); end
        n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL div_no_flag: got %b want 0", div_zero); end
        @(posedge clk);
        #1;
        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc);
        n_cmp++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_wrap_quo: got %h want 80000000", lo); end
        n_cmp++; if (hi !== 32'h0000_0000) begin n_fail++; $display("FAIL div_wrap_rem: got %h want 00000000", hi); end
        n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL div_wrap_flag: got %b want 0", div_zero); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_div_zero();
        int cyc;
        // 0x2211 / 0x100 leaves quotient 0x22 and remainder 0x11 as the prior result.
        start_op(OP_DIV, 32'h0000_2211, 32'h0000_0100);
        wait_done(cyc);
        n_cmp++; if (lo !== 32'h22) begin n_fail++; $display("FAIL dz_setup_lo: got %h want 00000022", lo); end
        n_cmp++; if (hi !== 32'h11) begin n_fail++; $display("FAIL dz_setup_hi: got %h want 00000011", hi); end
        @(posedge clk);
        #1;
        start_op(OP_DIV, 32'd5, 32'd0);
        n_cmp++; if (done !== 1'b1)     begin n_fail++; $display("FAIL dz_done_t0: got %b want 1", done); end
        n_cmp++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", div_zero); end
        n_cmp++; if (hi !== 32'h11)     begin n_fail++; $display("FAIL dz_hi_kept: got %h want 00000011", hi); end
        n_cmp++; if (lo !== 32'h22)     begin n_fail++; $display("FAIL dz_lo_kept: got %h want 00000022", lo); end
        @(posedge clk);
        #1;
        n_cmp++; if (done !== 1'b0)     begin n_fail++; $display("FAIL dz_done_t1: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL dz_busy_t1: got %b want 0", busy); end
        n_cmp++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag_hold: got %b want 1", div_zero); end
        start_op(OP_MULT, 32'd3, 32'd4);
        n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL dz_flag_clear: got %b want 0", div_zero); end
        wait_done(cyc);
        n_cmp++; if (lo !== 32'd12) begin n_fail++; $display("FAIL dz_next_mult: got %h want 0000000c", lo); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_ignored();
        int done_at;
        done_at = -1;
        start_op(OP_MULT, 32'd1000, 32'd1000);
        for (int i = 1; i <= 33; i++) begin
            if (i == 5) begin
                start = 1'b1;
                op    = OP_DIV;
                a     = 32'd9;
                b     = 32'd0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done && done_at < 0) done_at = i;
        end
        n_cmp++; if (done_at !== 32) begin n_fail++; $display("FAIL ign_done_edge: got %0d want 32", done_at); end
        n_cmp++; if (lo !== 32'h000F_4240) begin n_fail++; $display("FAIL ign_lo: got %h want 000f4240", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL ign_hi: got %h want 00000000", hi); end
        n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL ign_no_flag: got %b want 0", div_zero); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_midop();
        int cyc;
        int saw_done;
        saw_done = 0;
        start_op(OP_MULT, 32'd9, 32'd9);
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
        end
        #3 reset_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'h0)  begin n_fail++; $display("FAIL abort_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0)  begin n_fail++; $display("FAIL abort_lo: got %h want 0", lo); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        n_cmp++; if (saw_done !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", saw_done); end
        start_op(OP_MULT, 32'd6, 32'd7);
        wait_done(cyc);
        n_cmp++; if (cyc !== 32)     begin n_fail++; $display("FAIL fresh_latency: got %0d want 32", cyc); end
        n_cmp++; if (lo !== 32'd42)  begin n_fail++; $display("FAIL fresh_lo: got %h want 0000002a", lo); end
        n_cmp++; if (hi !== 32'd0)   begin n_fail++; $display("FAIL fresh_hi: got %h want 00000000", hi); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_start_ignored();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
